// File: rtl/timer_counter.sv
// timer_counter
//   Memory-mapped timer peripheral behind the CPU bus bridge. Holds a
//   programmable divider and a 32-bit tick counter that advances once every
//   `divider` clock cycles. The CPU writes the divider at PERI_ADDR_TIMER_SET
//   and reads the counter at PERI_ADDR_TIMER.
//
// Parameters
//   DEFAULT_DIV          divider loaded at reset
//   PERI_ADDR_TIMER      read address of the counter
//   PERI_ADDR_TIMER_SET  write address of the divider
//
// Ports
//   clk        in   1   system clock (same clock as the CPU/bridge)
//   rst        in   1   asynchronous, active-low reset
//   addr       in   32  read address from the bridge timer read path
//   set_addr   in   32  write address from the bridge timer-set path
//   set_we     in   1   write enable from the bridge
//   set_wdata  in   32  new divider value
//   rdata      out  32  counter value when addr matches, else 0
//   tick       out  1   registered one-cycle pulse per counter increment
module timer_counter #(
  parameter logic [31:0] DEFAULT_DIV         = 32'd100_000,
  parameter logic [31:0] PERI_ADDR_TIMER     = 32'h1000_0010,
  parameter logic [31:0] PERI_ADDR_TIMER_SET = 32'h1000_0014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] set_addr,
  input  logic        set_we,
  input  logic [31:0] set_wdata,
  output logic [31:0] rdata,
  output logic        tick
);

  logic [31:0] div_reg;
  logic [31:0] presc;
  logic [31:0] count;
  logic        write_hit;

  // The enable alone is not trusted; the address must match as well so a
  // stray enable from the bridge cannot reprogram the timer.
  assign write_hit = set_we && (set_addr == PERI_ADDR_TIMER_SET);

  // A write always wins over an increment in the same cycle and restarts
  // counting from zero. A divider of zero freezes prescaler and counter; that
  // case is filtered out before the div_reg - 1 compare so the compare never
  // sees an underflowed value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg <= DEFAULT_DIV;
      presc   <= 32'd0;
      count   <= 32'd0;
      tick    <= 1'b0;
    end else if (write_hit) begin
      div_reg <= set_wdata;
      presc   <= 32'd0;
      count   <= 32'd0;
      tick    <= 1'b0;
    end else if (div_reg != 32'd0) begin
      if (presc == div_reg - 32'd1) begin
        presc <= 32'd0;
        count <= count + 32'd1;
        tick  <= 1'b1;
      end else begin
        presc <= presc + 32'd1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Combinational read so the bridge can mux the data in the same cycle.
  assign rdata = (addr == PERI_ADDR_TIMER) ? count : 32'h0;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter
//   Bench for timer_counter. The reference model tracks the divider, the
//   number of edges since the last write and a counter base, and derives the
//   expected count and tick with plain arithmetic.
module tb_timer_counter;

  // A reduced reset divider keeps the reset-default run short.
  localparam logic [31:0] DEF_DIV    = 32'd1000;
  localparam logic [31:0] ADDR_TIMER = 32'h1000_0010;
  localparam logic [31:0] ADDR_SET   = 32'h1000_0014;
  localparam logic [31:0] ADDR_SW    = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] set_addr;
  logic        set_we;
  logic [31:0] set_wdata;
  logic [31:0] rdata;
  logic        tick;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [31:0]     mDiv;
  longint unsigned mCycles;
  logic [31:0]     mBase;

  timer_counter #(
    .DEFAULT_DIV        (DEF_DIV),
    .PERI_ADDR_TIMER    (ADDR_TIMER),
    .PERI_ADDR_TIMER_SET(ADDR_SET)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .set_addr (set_addr),
    .set_we   (set_we),
    .set_wdata(set_wdata),
    .rdata    (rdata),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a report.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish failures=%0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] modelCount();
    if (mDiv == 32'd0) return mBase;
    return mBase + 32'(mCycles / mDiv);
  endfunction

  function automatic logic modelTick();
    return (mDiv != 32'd0) && (mCycles != 0) && ((mCycles % mDiv) == 0);
  endfunction

  function automatic logic [31:0] modelRdata(input logic [31:0] a);
    return (a == ADDR_TIMER) ? modelCount() : 32'h0;
  endfunction

  task automatic modelReset();
    mDiv    = DEF_DIV;
    mCycles = 0;
    mBase   = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".rdata"}, rdata, modelRdata(addr));
    check({tag, ".tick"}, {31'b0, tick}, {31'b0, modelTick()});
  endtask

  // Drive one cycle's inputs at the falling edge, advance the model at the
  // rising edge, and return at the next falling edge.
  task automatic applyStimulus(input logic we, input logic [31:0] sa,
                               input logic [31:0] wd, input logic [31:0] ra);
    set_we    = we;
    set_addr  = sa;
    set_wdata = wd;
    addr      = ra;
    @(posedge clk);
    if (we && sa == ADDR_SET) begin
      mDiv    = wd;
      mCycles = 0;
      mBase   = 32'd0;
    end else if (mDiv != 32'd0) begin
      mCycles++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [31:0] ra);
    repeat (n) applyStimulus(1'b0, ADDR_SET, 32'd0, ra);
  endtask

  initial begin
    logic [31:0] oldCount;
    logic [31:0] ra;
    logic [31:0] sa;
    int r;

    rst = 1'b0; set_we = 1'b0; set_addr = 32'd0; set_wdata = 32'd0;
    addr = ADDR_TIMER;
    modelReset();
    @(negedge clk);
    checkOutput("reset");
    check("reset.div_reg", dut.div_reg, DEF_DIV);
    rst = 1'b1;

    // Default divider: one increment after DEF_DIV edges.
    idle(int'(DEF_DIV) - 1, ADDR_TIMER);
    checkOutput("default.before");
    idle(1, ADDR_TIMER);
    checkOutput("default.first");
    addr = ADDR_SW;
    #1;
    checkOutput("default.swaddr");

    // Divider 4 for 20 cycles.
    applyStimulus(1'b1, ADDR_SET, 32'd4, ADDR_TIMER);
    checkOutput("div4.write");
    for (int i = 0; i < 20; i++) begin
      idle(1, ADDR_TIMER);
      checkOutput("div4.run");
    end

    // Divider 1: tick stays high.
    applyStimulus(1'b1, ADDR_SET, 32'd1, ADDR_TIMER);
    for (int i = 0; i < 10; i++) begin
      idle(1, ADDR_TIMER);
      checkOutput("div1.run");
    end

    // Enable with a non-matching address must be ignored.
    applyStimulus(1'b1, ADDR_TIMER, 32'd2, ADDR_TIMER);
    checkOutput("stray.we");

    // Divider 0 stops the timer; a later nonzero write restarts it.
    applyStimulus(1'b1, ADDR_SET, 32'd1, ADDR_TIMER);
    idle(7, ADDR_TIMER);
    checkOutput("stop.pre");
    applyStimulus(1'b1, ADDR_SET, 32'd0, ADDR_TIMER);
    checkOutput("stop.write");
    idle(50, ADDR_TIMER);
    checkOutput("stop.hold");
    applyStimulus(1'b1, ADDR_SET, 32'd3, ADDR_TIMER);
    checkOutput("restart.write");
    idle(3, ADDR_TIMER);
    checkOutput("restart.first");

    // Counter wrap with divider 1.
    applyStimulus(1'b1, ADDR_SET, 32'd1, ADDR_TIMER);
    idle(2, ADDR_TIMER);
    force dut.count = 32'hFFFF_FFFE;
    #1;
    release dut.count;
    mBase = 32'hFFFF_FFFE - 32'(mCycles / mDiv);
    checkOutput("wrap.forced");
    idle(1, ADDR_TIMER);
    checkOutput("wrap.max");
    idle(1, ADDR_TIMER);
    checkOutput("wrap.zero");

    // Asynchronous reset in the middle of counting.
    applyStimulus(1'b1, ADDR_SET, 32'd5, ADDR_TIMER);
    idle(17, ADDR_TIMER);
    checkOutput("async.pre");
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async.reset");
    check("async.div_reg", dut.div_reg, DEF_DIV);
    @(negedge clk);
    checkOutput("async.held");
    rst = 1'b1;
    idle(3, ADDR_TIMER);
    checkOutput("async.resume");

    // Write and read in the same cycle.
    applyStimulus(1'b1, ADDR_SET, 32'd2, ADDR_TIMER);
    idle(5, ADDR_TIMER);
    set_we = 1'b1; set_addr = ADDR_SET; set_wdata = 32'd9; addr = ADDR_TIMER;
    #1;
    oldCount = modelCount();
    check("rw.old", rdata, oldCount);
    applyStimulus(1'b1, ADDR_SET, 32'd9, ADDR_TIMER);
    checkOutput("rw.after");

    // Back-to-back writes, last wins.
    applyStimulus(1'b1, ADDR_SET, 32'd3, ADDR_TIMER);
    checkOutput("b2b.1");
    applyStimulus(1'b1, ADDR_SET, 32'd5, ADDR_TIMER);
    checkOutput("b2b.2");
    applyStimulus(1'b1, ADDR_SET, 32'd7, ADDR_TIMER);
    checkOutput("b2b.3");
    check("b2b.div_reg", dut.div_reg, 32'd7);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 2))
        0:       ra = ADDR_TIMER;
        1:       ra = ADDR_SW;
        default: ra = $urandom;
      endcase
      if (r < 3) begin
        applyStimulus(1'b1, ADDR_SET, $urandom_range(0, 6), ra);
      end else if (r < 6) begin
        sa = $urandom;
        if (sa == ADDR_SET) sa = ADDR_SW;
        applyStimulus(1'b1, sa, $urandom, ra);
      end else begin
        applyStimulus(1'b0, $urandom, $urandom, ra);
      end
      checkOutput("random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
